btn_move_conditioner: RTL and testbench

Input-conditioning stage between the raw left/right push-buttons on the dedicated inputs and the sprite-position logic of the VGA demo. It synchronises and debounces both buttons, arbitrates them into one movement direction, and emits single-cycle step pulses. Pulses start at a slow rate and accelerate to a fast rate while the button is held. The position logic consumes the pulses directly and moves the sprite one pixel per pulse.

---
 rtl/btn_move_conditioner.sv | 174 +++++++++++++++++
 tb/tb_btn_move_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_move_conditioner.sv
// Button conditioner: synchronise and debounce left/right, arbitrate a direction, emit step pulses.
// Optional macro BTN_COND_ACCEL_EN enables the SLOW->FAST acceleration; without it every step is at the FAST rate.
module btn_move_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES  = 250000,
  parameter int unsigned SLOW_STEP_CYCLES = 468750,
  parameter int unsigned FAST_STEP_CYCLES = 234375,
  parameter int unsigned ACCEL_STEPS      = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  output logic left_level,
  output logic right_level,
  output logic step_left,
  output logic step_right,
  output logic dir_conflict
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Interval counter is shared by both cadences, so it is sized for the longer one
  localparam int unsigned IVAL_MAX = (SLOW_STEP_CYCLES > FAST_STEP_CYCLES) ?
                                     SLOW_STEP_CYCLES : FAST_STEP_CYCLES;
  localparam int unsigned IVAL_W = $clog2(IVAL_MAX + 1);
  localparam logic [IVAL_W-1:0] FAST_LAST = IVAL_W'(FAST_STEP_CYCLES - 1);

`ifdef BTN_COND_ACCEL_EN
  localparam logic [IVAL_W-1:0] SLOW_LAST = IVAL_W'(SLOW_STEP_CYCLES - 1);
  localparam int unsigned STEP_W = $clog2(ACCEL_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_SAT    = STEP_W'(ACCEL_STEPS);
  localparam logic [STEP_W-1:0] STEP_BEFORE = STEP_W'(ACCEL_STEPS - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_SLOW, ST_FAST} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FAST} state_t;
`endif

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

  logic [1:0] raw;
  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic [1:0] level_q;

  assign raw = {btn_right_raw, btn_left_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            lvl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_q[b] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        lvl <= ~lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign level_q[b] = lvl;
  end

  dir_t dir;

  always_comb begin
    dir = DIR_NONE;
    if (level_q == 2'b01)
      dir = DIR_LEFT;
    else if (level_q == 2'b10)
      dir = DIR_RIGHT;
  end

  assign left_level   = level_q[0];
  assign right_level  = level_q[1];
  assign dir_conflict = &level_q;

  state_t            state;
  dir_t              cur_dir;
  logic [IVAL_W-1:0] ival;
  logic              pulse_l_q;
  logic              pulse_r_q;
`ifdef BTN_COND_ACCEL_EN
  logic [STEP_W-1:0] step_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_dir   <= DIR_NONE;
      ival      <= '0;
      pulse_l_q <= 1'b0;
      pulse_r_q <= 1'b0;
`ifdef BTN_COND_ACCEL_EN
      step_cnt  <= '0;
`endif
    end else begin
      pulse_l_q <= 1'b0;
      pulse_r_q <= 1'b0;
      if (dir != cur_dir) begin
        // A new direction restarts the cadence; the entry pulse counts as the first step
        cur_dir <= dir;
        ival    <= '0;
        if (dir == DIR_NONE) begin
          state <= ST_IDLE;
`ifdef BTN_COND_ACCEL_EN
          step_cnt <= '0;
`endif
        end else begin
          pulse_l_q <= (dir == DIR_LEFT);
          pulse_r_q <= (dir == DIR_RIGHT);
`ifdef BTN_COND_ACCEL_EN
          step_cnt <= STEP_W'(1);
          state    <= (ACCEL_STEPS <= 1) ? ST_FAST : ST_SLOW;
`else
          state    <= ST_FAST;
`endif
        end
      end else begin
        case (state)
          ST_IDLE: ival <= '0;
`ifdef BTN_COND_ACCEL_EN
          ST_SLOW: begin
            if (ival == SLOW_LAST) begin
              ival      <= '0;
              pulse_l_q <= (cur_dir == DIR_LEFT);
              pulse_r_q <= (cur_dir == DIR_RIGHT);
              step_cnt  <= step_cnt + 1'b1;
              if (step_cnt == STEP_BEFORE)
                state <= ST_FAST;
            end else begin
              ival <= ival + 1'b1;
            end
          end
`endif
          ST_FAST: begin
            if (ival == FAST_LAST) begin
              ival      <= '0;
              pulse_l_q <= (cur_dir == DIR_LEFT);
              pulse_r_q <= (cur_dir == DIR_RIGHT);
`ifdef BTN_COND_ACCEL_EN
              if (step_cnt != STEP_SAT)
                step_cnt <= step_cnt + 1'b1;
`endif
            end else begin
              ival <= ival + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Gating with the live direction drops a pulse that collides with a release, reversal or conflict
  assign step_left  = pulse_l_q & (dir == DIR_LEFT);
  assign step_right = pulse_r_q & (dir == DIR_RIGHT);

endmodule

// File: tb/tb_btn_move_conditioner.sv
// Directed bench for btn_move_conditioner with small parameters (debounce 4, slow 8, fast 3, accel 2).
// Expected cadence follows BTN_COND_ACCEL_EN: 8-cycle first gap when defined, 3-cycle gaps otherwise.
module tb_btn_move_conditioner;

  localparam int DB    = 4;
  localparam int SLOW  = 8;
  localparam int FAST  = 3;
  localparam int ACCEL = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_left_raw;
  logic btn_right_raw;
  logic left_level;
  logic right_level;
  logic step_left;
  logic step_right;
  logic dir_conflict;

  int checks = 0;
  int errors = 0;

  btn_move_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .SLOW_STEP_CYCLES(SLOW),
    .FAST_STEP_CYCLES(FAST),
    .ACCEL_STEPS     (ACCEL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_left_raw (btn_left_raw),
    .btn_right_raw(btn_right_raw),
    .left_level   (left_level),
    .right_level  (right_level),
    .step_left    (step_left),
    .step_right   (step_right),
    .dir_conflict (dir_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic left, input logic right);
    btn_left_raw  = left;
    btn_right_raw = right;
  endtask

  task automatic check_output(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  function automatic logic pulse_of(input logic right_sel);
    return right_sel ? step_right : step_left;
  endfunction

  function automatic logic level_of(input logic right_sel);
    return right_sel ? right_level : left_level;
  endfunction

  // Gap between pulse k and pulse k+1 after a direction is entered
  function automatic int gap_for(input int k);
`ifdef BTN_COND_ACCEL_EN
    return (k < ACCEL) ? SLOW : FAST;
`else
    return FAST;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_left_level"}, left_level, 1'b0);
    check_output({tag, "_right_level"}, right_level, 1'b0);
    check_output({tag, "_step_left"}, step_left, 1'b0);
    check_output({tag, "_step_right"}, step_right, 1'b0);
    check_output({tag, "_conflict"}, dir_conflict, 1'b0);
  endtask

  // Caller has just raised the input (or released reset); level rises on the 6th edge, pulse on the 7th
  task automatic wait_rise(input logic right_sel, input string tag);
    tick(5);
    check_output({tag, "_early"}, level_of(right_sel), 1'b0);
    tick(1);
    check_output({tag, "_level"}, level_of(right_sel), 1'b1);
    check_output({tag, "_nopulse"}, pulse_of(right_sel), 1'b0);
    tick(1);
    check_output({tag, "_first"}, pulse_of(right_sel), 1'b1);
    check_output({tag, "_first_other"}, pulse_of(!right_sel), 1'b0);
  endtask

  task automatic expect_gap(input logic right_sel, input int gap, input string tag);
    for (int i = 1; i < gap; i++) begin
      tick(1);
      check_output({tag, "_gap"}, pulse_of(right_sel), 1'b0);
    end
    tick(1);
    check_output({tag, "_pulse"}, pulse_of(right_sel), 1'b1);
    check_output({tag, "_other"}, pulse_of(!right_sel), 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);
    check_all_zero("post_reset");

    // Bounce: never stable for DB cycles, so nothing may get through
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        btn_left_raw = ~btn_left_raw;
      tick(1);
      check_output("bounce_level", left_level, 1'b0);
      check_output("bounce_step", step_left, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0);
    tick(8);
    check_all_zero("bounce_settled");

    // Clean hold of left
    apply_stimulus(1'b1, 1'b0);
    wait_rise(1'b0, "hold");
    expect_gap(1'b0, gap_for(1), "hold_g1");
    expect_gap(1'b0, gap_for(2), "hold_g2");
    expect_gap(1'b0, gap_for(3), "hold_g3");

    // Release in FAST: one more scheduled pulse before the level falls, the colliding one is dropped
    apply_stimulus(1'b0, 1'b0);
    tick(3);
    check_output("rel_last_pulse", step_left, 1'b1);
    tick(2);
    check_output("rel_level_still", left_level, 1'b1);
    tick(1);
    check_output("rel_level_fall", left_level, 1'b0);
    check_output("rel_suppressed", step_left, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_output("rel_quiet", step_left, 1'b0);
    end

    // Re-press restarts the cadence from the beginning
    apply_stimulus(1'b1, 1'b0);
    wait_rise(1'b0, "repress");
    expect_gap(1'b0, gap_for(1), "repress_g1");

    // Asynchronous reset right on a pulse cycle
    rst_n = 1'b0;
    #1;
    check_output("async_rst_step", step_left, 1'b0);
    check_output("async_rst_level", left_level, 1'b0);
    tick(2);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    wait_rise(1'b0, "post_rst");
    expect_gap(1'b0, gap_for(1), "post_rst_g1");
    expect_gap(1'b0, gap_for(2), "post_rst_g2");

    // Conflict: add right while left is held
    apply_stimulus(1'b1, 1'b1);
    tick(3);
    check_output("pre_conf_pulse", step_left, 1'b1);
    tick(2);
    check_output("pre_conf_flag", dir_conflict, 1'b0);
    tick(1);
    check_output("conf_flag", dir_conflict, 1'b1);
    check_output("conf_right_level", right_level, 1'b1);
    check_output("conf_no_left", step_left, 1'b0);
    check_output("conf_no_right", step_right, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_output("conf_hold_flag", dir_conflict, 1'b1);
      check_output("conf_hold_left", step_left, 1'b0);
      check_output("conf_hold_right", step_right, 1'b0);
    end

    // Release left: right takes over with a fresh cadence
    apply_stimulus(1'b0, 1'b1);
    tick(5);
    check_output("unconf_still", dir_conflict, 1'b1);
    tick(1);
    check_output("unconf_flag", dir_conflict, 1'b0);
    check_output("unconf_left_level", left_level, 1'b0);
    check_output("unconf_nopulse", step_right, 1'b0);
    tick(1);
    check_output("right_first", step_right, 1'b1);
    check_output("right_first_other", step_left, 1'b0);
    expect_gap(1'b1, gap_for(1), "right_g1");
    expect_gap(1'b1, gap_for(2), "right_g2");

    apply_stimulus(1'b0, 1'b0);
    tick(10);
    check_all_zero("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
